stream_pipeline: RTL
====================

Name: stream_pipeline

Overview:
Elastic, parametrised data pipeline with a valid/ready handshake. It is the successor to the fixed-latency shift pipeline and adds backpressure, bubble collapsing, flush and a selectable registered-ready mode. It sits between stream blocks in the parser datapath (for example MAC RX, then header parser, then output FIFO) to break timing paths without dropping or duplicating beats.

Parameters:
DATA_W, 32, payload width in bits.
PIPE_DEPTH, 2, number of register stages; 0 means combinational pass-through.
REG_READY, 1, 1 = every stage is a 2-entry skid stage with registered s_ready; 0 = single-register stages with combinational ready chain.
RESET_EN, 1, 1 = data registers also load RESET_VALUE on rst; valid flags are always reset.
RESET_VALUE, 0, data reset value, truncated/zero-extended to DATA_W.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
flush_i  input  1  synchronous discard of all in-flight beats.
s_valid_i  input  1  upstream beat valid.
s_ready_o  output  1  pipeline can accept a beat.
s_data_i  input  DATA_W  upstream payload.
m_valid_o  output  1  downstream beat valid.
m_ready_i  input  1  downstream accepts beat.
m_data_o  output  DATA_W  downstream payload.
occupancy_o  output  $clog2(2*PIPE_DEPTH+1)  beats held; present only with STREAM_PIPE_OCCUPANCY_EN.

Behaviour:
- Transfer occurs on any edge where valid && ready, on each side independently. Beats leave in order, each exactly once.
- Reset, on the edge where rst=1:
  - All stage and skid valids go to 0, so m_valid_o=0 and s_ready_o=1 in the next cycle.
  - Data registers load RESET_VALUE if RESET_EN, otherwise they are held.
  - rst overrides flush_i and any handshake in the same cycle.
- flush_i=1 clears every valid on the edge. A beat offered on s_* in the same cycle is discarded even if s_ready_o=1. The downstream handshake in that cycle still completes for m_data_o as presented. Data contents are not cleared.
- REG_READY=0, stage k:
  - ready_k = !valid_k || ready_{k+1}.
  - Bubbles collapse: an empty stage accepts regardless of downstream.
  - Capacity is PIPE_DEPTH beats.
- REG_READY=1, each stage has main and skid registers:
  - s_ready of the stage = !skid_valid (registered).
  - If main is valid, downstream stalls and input is accepted, the input goes to skid.
  - When downstream accepts: skid moves to main if skid is valid; else input goes to main if accepted; else main empties.
  - Capacity is 2*PIPE_DEPTH beats. No combinational path from m_ready_i to s_ready_o.
- Latency (unstalled, empty pipe): a beat accepted at edge N is presented on m_* after edge N+PIPE_DEPTH-1, i.e. PIPE_DEPTH cycles of register delay. Throughput is 1 beat/cycle in both modes.
- PIPE_DEPTH=0: m_valid_o=s_valid_i, m_data_o=s_data_i, s_ready_o=m_ready_i. flush_i and rst have no effect; occupancy_o=0.
- m_valid_o must not drop and m_data_o must not change while m_valid_o && !m_ready_i, except on rst or flush_i.
- Full condition: s_ready_o=0 only when all storage is full and m_ready_i=0 (mode 0). In mode 1, s_ready_o=0 only when the input stage skid is full.

Optional Feature:
STREAM_PIPE_OCCUPANCY_EN:
- Defined: adds port occupancy_o, a registered count of valid entries across all stages. Update rule: +1 on input accept, -1 on output accept, no change when both occur. Forced to 0 on rst or flush_i. Must match the sum of the valid flags every cycle; SVA provided under the same macro.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
1. Streaming, DEPTH=3, REG_READY=1, m_ready_i=1: send 0x01..0x10 back-to-back -> first beat out 3 cycles after accept, then 16 consecutive beats in order, s_ready_o held at 1.
2. Backpressure, DEPTH=2, REG_READY=1: stream continuously with m_ready_i=0 -> exactly 4 beats accepted, then s_ready_o=0. Release m_ready_i -> 0x01..0x04 out in order, no loss or duplicates, m_data_o stable while stalled.
3. Bubble collapse, DEPTH=4, REG_READY=0: one beat 0xAA, m_ready_i=0 -> s_ready_o stays 1 for 3 more accepts, drops after the 4th.
4. Flush: 3 beats in flight, flush_i for 1 cycle with s_valid_i=1 and data 0x55 -> next cycle m_valid_o=0, occupancy_o=0, 0x55 never emitted.
5. Reset mid-stall: pipe full, rst pulse -> m_valid_o=0, s_ready_o=1, m_data_o=RESET_VALUE (RESET_EN=1); a subsequent 0x77 emerges after PIPE_DEPTH cycles.
6. DEPTH=0: random valid/ready/data -> outputs equal inputs combinationally in the same cycle.

Source files
------------

// File: rtl/stream_pipeline.sv
// Elastic valid/ready register pipeline with flush; skid or plain stages.
// Define STREAM_PIPE_OCCUPANCY_EN to add occupancy_o and its assertion.
module stream_pipeline #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PIPE_DEPTH  = 2,
   parameter bit          REG_READY   = 1'b1,
   parameter bit          RESET_EN    = 1'b1,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DATA_W-1:0] m_data_o
`ifdef STREAM_PIPE_OCCUPANCY_EN
   ,
   output logic [((PIPE_DEPTH == 0) ? 1 : $clog2(2*PIPE_DEPTH+1))-1:0]
                             occupancy_o
`endif
);

   localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(RESET_VALUE);

   if (PIPE_DEPTH == 0) begin : g_pass
      assign m_valid_o = s_valid_i;
      assign m_data_o  = s_data_i;
      assign s_ready_o = m_ready_i;
`ifdef STREAM_PIPE_OCCUPANCY_EN
      assign occupancy_o = '0;
`endif
   end else begin : g_pipe
      localparam int unsigned D = PIPE_DEPTH;

      logic [D-1:0]      main_v_q;
      logic [D-1:0]      main_v_d;
      logic [D-1:0]      skid_v_q;
      logic [D-1:0]      skid_v_d;
      logic [DATA_W-1:0] main_d_q [D];
      logic [DATA_W-1:0] main_d_d [D];
      logic [DATA_W-1:0] skid_d_q [D];
      logic [DATA_W-1:0] skid_d_d [D];

      logic [D:0]        rdy;
      logic [D-1:0]      in_v;
      logic [DATA_W-1:0] in_d [D];
      logic [D-1:0]      acc;
      logic [D-1:0]      pop;

      // Skid mode: ready is a flop; plain mode: ready ripples from m_ready_i.
      always_comb begin
         rdy    = '0;
         rdy[D] = m_ready_i;
         for (int k = int'(D) - 1; k >= 0; k--) begin
            if (REG_READY) begin
               rdy[k] = !skid_v_q[k];
            end else begin
               rdy[k] = !main_v_q[k] || rdy[k+1];
            end
         end
      end

      always_comb begin
         in_v[0] = s_valid_i;
         in_d[0] = s_data_i;
         for (int k = 1; k < int'(D); k++) begin
            in_v[k] = main_v_q[k-1];
            in_d[k] = main_d_q[k-1];
         end
      end

      always_comb begin
         for (int k = 0; k < int'(D); k++) begin
            acc[k] = in_v[k] && rdy[k];
            pop[k] = main_v_q[k] && rdy[k+1];
         end
      end

      always_comb begin
         main_v_d = main_v_q;
         skid_v_d = skid_v_q;
         main_d_d = main_d_q;
         skid_d_d = skid_d_q;
         for (int k = 0; k < int'(D); k++) begin
            if (REG_READY) begin
               if (!main_v_q[k] || pop[k]) begin
                  if (skid_v_q[k]) begin
                     main_v_d[k] = 1'b1;
                     main_d_d[k] = skid_d_q[k];
                     skid_v_d[k] = 1'b0;
                  end else begin
                     main_v_d[k] = acc[k];
                     if (acc[k]) begin
                        main_d_d[k] = in_d[k];
                     end
                  end
               end else if (acc[k]) begin
                  skid_v_d[k] = 1'b1;
                  skid_d_d[k] = in_d[k];
               end
            end else if (rdy[k]) begin
               main_v_d[k] = in_v[k];
               if (in_v[k]) begin
                  main_d_d[k] = in_d[k];
               end
            end
         end
      end

      // Flush only kills valids; payload registers keep loading.
      always_ff @(posedge clk) begin
         if (rst) begin
            main_v_q <= '0;
            skid_v_q <= '0;
            if (RESET_EN) begin
               for (int k = 0; k < int'(D); k++) begin
                  main_d_q[k] <= RST_DATA;
                  skid_d_q[k] <= RST_DATA;
               end
            end
         end else begin
            main_v_q <= flush_i ? '0 : main_v_d;
            skid_v_q <= flush_i ? '0 : skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
         end
      end

      assign s_ready_o = rdy[0];
      assign m_valid_o = main_v_q[D-1];
      assign m_data_o  = main_d_q[D-1];

`ifdef STREAM_PIPE_OCCUPANCY_EN
      localparam int unsigned OCC_W = $clog2(2*D+1);

      logic [OCC_W-1:0] occ_q;
      logic [OCC_W-1:0] occ_d;
      logic [OCC_W-1:0] vsum;

      always_comb begin
         occ_d = occ_q;
         if (acc[0] && !pop[D-1]) begin
            occ_d = occ_q + OCC_W'(1);
         end else if (!acc[0] && pop[D-1]) begin
            occ_d = occ_q - OCC_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst || flush_i) begin
            occ_q <= '0;
         end else begin
            occ_q <= occ_d;
         end
      end

      always_comb begin
         vsum = '0;
         for (int k = 0; k < int'(D); k++) begin
            vsum = vsum + OCC_W'(main_v_q[k]) + OCC_W'(skid_v_q[k]);
         end
      end

      assign occupancy_o = occ_q;

      a_occ_sum: assert property (
         @(posedge clk) disable iff (rst) occ_q == vsum
      );
`endif
   end

endmodule
